// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision multiply path.
// Operand classification helpers treat exp==0 as zero (flush-to-zero).
package fp16_pkg;

    localparam int FP16_W       = 16;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE,
        EXP,
        MUL,
        NORM,
        DONE
    } state_t;

    function automatic logic is_zero(input logic [FP16_W-1:0] x);
        return x[14:10] == 5'd0;
    endfunction

    function automatic logic is_inf(input logic [FP16_W-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic is_nan(input logic [FP16_W-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/fp16_exp_bias_add.sv
// Registered biased exponent sum: sum = ea + eb - BIAS as a signed value
// two bits wider than the exponent field, loaded while en is high.
module fp16_exp_bias_add
    import fp16_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int BIAS  = FP16_BIAS,
    parameter int SUM_W = EXP_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [EXP_W-1:0]        ea,
    input  logic [EXP_W-1:0]        eb,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [SUM_W-1:0] sum_nxt;

    always_comb begin
        sum_nxt = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(SUM_W'(BIAS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_nxt;
        end
    end

endmodule

// File: rtl/fp16_mult_seq.sv
// Multi-cycle fp16 multiplier: exponent add, 11-step shift-add significand
// product, normalise and pack. Define FP16_RNE_EN for round-to-nearest-even.
module fp16_mult_seq
    import fp16_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = FP16_BIAS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_a,
    input  logic [FP16_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] out_res,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_nan
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int SUM_W  = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    state_t              state;
    logic [FP16_W-1:0]   a_r;
    logic [FP16_W-1:0]   b_r;
    logic                sign_r;
    logic [PROD_W-1:0]   mcand;
    logic [SIG_W-1:0]    mplier;
    logic [PROD_W-1:0]   prod;
    logic [CNT_W-1:0]    cnt;
    logic signed [SUM_W-1:0] e_sum;

    logic                sign_ab;
    logic                nan_case;
    logic                inf_case;
    logic                zero_case;
    logic                prod_hi;
    logic [MAN_W-1:0]    man;
    logic signed [SUM_W-1:0] e_adj;
    logic [MAN_W-1:0]    man_fin;
    logic signed [SUM_W-1:0] e_fin;

    fp16_exp_bias_add #(
        .EXP_W (EXP_W),
        .BIAS  (BIAS),
        .SUM_W (SUM_W)
    ) u_exp_add (
        .clk (clk),
        .rst (rst),
        .en  (state == EXP),
        .ea  (a_r[FP16_W-2 -: EXP_W]),
        .eb  (b_r[FP16_W-2 -: EXP_W]),
        .sum (e_sum)
    );

    // Subnormal operands classify as zero, so inf * subnormal is NaN.
    always_comb begin
        sign_ab   = a_r[FP16_W-1] ^ b_r[FP16_W-1];
        nan_case  = is_nan(a_r) || is_nan(b_r)
                    || (is_inf(a_r) && is_zero(b_r))
                    || (is_zero(a_r) && is_inf(b_r));
        inf_case  = is_inf(a_r) || is_inf(b_r);
        zero_case = is_zero(a_r) || is_zero(b_r);
    end

`ifdef FP16_RNE_EN
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W:0]   man_rnd;

    always_comb begin
        prod_hi = prod[PROD_W-1];
        e_adj   = e_sum + $signed({{(SUM_W-1){1'b0}}, prod_hi});
        if (prod_hi) begin
            man    = prod[PROD_W-2 -: MAN_W];
            guard  = prod[PROD_W-2-MAN_W];
            sticky = |prod[PROD_W-3-MAN_W:0];
        end else begin
            man    = prod[PROD_W-3 -: MAN_W];
            guard  = prod[PROD_W-3-MAN_W];
            sticky = |prod[PROD_W-4-MAN_W:0];
        end
        round_up = guard && (sticky || man[0]);
        man_rnd  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
        // Mantissa carry-out leaves the low bits zero and bumps the exponent.
        e_fin    = e_adj + $signed({{(SUM_W-1){1'b0}}, man_rnd[MAN_W]});
        man_fin  = man_rnd[MAN_W-1:0];
    end
`else
    always_comb begin
        prod_hi = prod[PROD_W-1];
        e_adj   = e_sum + $signed({{(SUM_W-1){1'b0}}, prod_hi});
        if (prod_hi) begin
            man = prod[PROD_W-2 -: MAN_W];
        end else begin
            man = prod[PROD_W-3 -: MAN_W];
        end
        e_fin   = e_adj;
        man_fin = man;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_nan   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        in_ready <= 1'b0;
                        state    <= EXP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EXP: begin
                    sign_r  <= sign_ab;
                    mcand   <= {{(PROD_W-SIG_W){1'b0}}, 1'b1, a_r[MAN_W-1:0]};
                    mplier  <= {1'b1, b_r[MAN_W-1:0]};
                    prod    <= '0;
                    cnt     <= '0;
                    out_ovf <= 1'b0;
                    out_unf <= 1'b0;
                    out_nan <= 1'b0;
                    if (nan_case) begin
                        out_res   <= FP16_QNAN;
                        out_nan   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (inf_case) begin
                        out_res   <= {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (zero_case) begin
                        out_res   <= {sign_ab, {(FP16_W-1){1'b0}}};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(MAN_W)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out_valid <= 1'b1;
                    out_nan   <= 1'b0;
                    state     <= DONE;
                    if (e_fin >= FP16_EXP_MAX) begin
                        out_res <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        out_ovf <= 1'b1;
                        out_unf <= 1'b0;
                    end else if (e_fin <= 0) begin
                        out_res <= {sign_r, {(FP16_W-1){1'b0}}};
                        out_ovf <= 1'b0;
                        out_unf <= 1'b1;
                    end else begin
                        out_res <= {sign_r, e_fin[EXP_W-1:0], man_fin};
                        out_ovf <= 1'b0;
                        out_unf <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mult_seq.sv
// Scoreboard bench for fp16_mult_seq: directed vectors push expectations,
// a negedge monitor pops and compares each accepted result and its latency.
module tb_fp16_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_res;
    logic        out_ovf;
    logic        out_unf;
    logic        out_nan;

    fp16_mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_OVF  = 3'b100;
    localparam logic [2:0] F_UNF  = 3'b010;
    localparam logic [2:0] F_NAN  = 3'b001;

`ifdef FP16_RNE_EN
    localparam logic [15:0] RND_RES = 16'h3E03;
`else
    localparam logic [15:0] RND_RES = 16'h3E02;
`endif

    typedef struct {
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   first_cyc = 0;
    bit   presenting = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            presenting = 1'b0;
        end else if (out_valid) begin
            if (!presenting) begin
                presenting = 1'b1;
                first_cyc  = cyc;
            end
            if (out_ready) begin
                presenting = 1'b0;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h with no pending operation", out_res);
                end else begin
                    mon_e = q.pop_front();
                    check({mon_e.name, "_res"}, {13'h0, out_res, out_ovf, out_unf, out_nan},
                          {13'h0, mon_e.res, mon_e.flg});
                    check({mon_e.name, "_lat"}, first_cyc - mon_e.acc, mon_e.lat);
                end
            end
        end
    end

    task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [2:0] flg, input int lat,
                         input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: in_ready stayed 0, expected 1", name);
            return;
        end
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        if (push) q.push_back('{res, flg, lat, cyc + 1, name});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", q[0].name, q.size());
            q.delete();
        end
    endtask

    task automatic op(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] res, input logic [2:0] flg, input int lat);
        issue(name, a, b, res, flg, lat, 1'b1);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {11'h0, in_ready, out_valid, out_res, out_ovf, out_unf, out_nan}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        op("one_x_one",    16'h3C00, 16'h3C00, 16'h3C00, F_NONE, 13);
        op("two_x_three",  16'h4000, 16'h4200, 16'h4600, F_NONE, 13);
        op("neg_two_x_3",  16'hC000, 16'h4200, 16'hC600, F_NONE, 13);
        op("neg_x_neg",    16'hC000, 16'hC200, 16'h4600, F_NONE, 13);
        op("one_x_negone", 16'h3C00, 16'hBC00, 16'hBC00, F_NONE, 13);
        op("onehalf_sq",   16'h3E00, 16'h3E00, 16'h4080, F_NONE, 13);
        op("max_sq",       16'h7BFF, 16'h7BFF, 16'h7C00, F_OVF,  13);
        op("negmax_sq",    16'hFBFF, 16'h7BFF, 16'hFC00, F_OVF,  13);
        op("ovf_edge",     16'h7800, 16'h4000, 16'h7C00, F_OVF,  13);
        op("big_ok",       16'h7800, 16'h3C00, 16'h7800, F_NONE, 13);
        op("min_sq",       16'h0400, 16'h0400, 16'h0000, F_UNF,  13);
        op("unf_edge",     16'h0400, 16'h3800, 16'h0000, F_UNF,  13);
        op("min_ok",       16'h0400, 16'h3C00, 16'h0400, F_NONE, 13);
        op("neg_unf",      16'h8400, 16'h0400, 16'h8000, F_UNF,  13);
        op("zero_x_inf",   16'h0000, 16'h7C00, 16'h7E00, F_NAN,  1);
        op("inf_x_two",    16'h7C00, 16'h4000, 16'h7C00, F_NONE, 1);
        op("inf_x_neg2",   16'h7C00, 16'hC000, 16'hFC00, F_NONE, 1);
        op("qnan_in",      16'h7E00, 16'h3C00, 16'h7E00, F_NAN,  1);
        op("snan_in",      16'h3C00, 16'h7C01, 16'h7E00, F_NAN,  1);
        op("negzero",      16'h8000, 16'h3C00, 16'h8000, F_NONE, 1);
        op("subnorm_ftz",  16'h0001, 16'h3C00, 16'h0000, F_NONE, 1);
        op("inf_x_subn",   16'h7C00, 16'h0001, 16'h7E00, F_NAN,  1);
        op("round",        16'h3E01, 16'h3C01, RND_RES,  F_NONE, 13);

        // Back-pressure: result must hold while a competing request is ignored.
        out_ready = 1'b0;
        issue("hold", 16'h4000, 16'h4200, 16'h4600, F_NONE, 13, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_a     = 16'h3C00;
        in_b     = 16'h3C00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_state", {11'h0, out_valid, in_ready, out_res, out_ovf, out_unf, out_nan},
                  {11'h0, 1'b1, 1'b0, 16'h4600, F_NONE});
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (20) @(negedge clk);
        check("hold_no_extra", {31'h0, out_valid}, 32'h0);

        // Reset while in MUL aborts the operation.
        issue("rst_abort", 16'h3C00, 16'h3C00, 16'h0, F_NONE, 13, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_state", {11'h0, in_ready, out_valid, out_res, out_ovf, out_unf, out_nan}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_result", {31'h0, seen}, 32'h0);

        op("after_rst", 16'h4000, 16'h4200, 16'h4600, F_NONE, 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
